// File: rtl/sd_req_arbiter_if.sv
// sd_req_arbiter_if
// Bundles the requester-side and host-side sector channel signals that
// the arbiter sits between.
//   master modport : the arbiter (drives host_* requests, steers ack/strobes)
//   slave modport  : the environment (per-drive controllers + host bridge)
// Requester i occupies bit i of the N_REQ-wide vectors, bits
// [i*LBA_W +: LBA_W] of req_lba and bits [i*8 +: 8] of req_buff_din.
interface sd_req_arbiter_if #(
    parameter int N_REQ = 3,
    parameter int LBA_W = 32
);
    logic [N_REQ-1:0]       req_rd;
    logic [N_REQ-1:0]       req_wr;
    logic [N_REQ*LBA_W-1:0] req_lba;
    logic [N_REQ*8-1:0]     req_buff_din;
    logic [N_REQ-1:0]       req_ack;
    logic [N_REQ-1:0]       req_buff_wr;
    logic                   host_rd;
    logic                   host_wr;
    logic [LBA_W-1:0]       host_lba;
    logic                   host_ack;
    logic                   host_buff_wr;
    logic [7:0]             host_buff_din;

    modport master (
        input  req_rd, req_wr, req_lba, req_buff_din, host_ack, host_buff_wr,
        output req_ack, req_buff_wr, host_rd, host_wr, host_lba, host_buff_din
    );

    modport slave (
        output req_rd, req_wr, req_lba, req_buff_din, host_ack, host_buff_wr,
        input  req_ack, req_buff_wr, host_rd, host_wr, host_lba, host_buff_din
    );
endinterface

// File: rtl/sd_req_arbiter.sv
// sd_req_arbiter
// Shares the single host sector channel between N_REQ block-device
// requesters (0 = floppy 1, 1 = HDD, 2 = floppy 2). Requests are granted
// round-robin, one sector transaction at a time; the LBA is latched at
// grant and the host ack / buffer strobes are steered to the winner only.
// A watchdog abandons a request the host never acknowledges.
// Ports:
//   clk         : clk_pixel_14_318 domain clock
//   reset       : synchronous, active-high
//   bus         : sd_req_arbiter_if.master (requester + host channel)
//   busy        : high whenever a transaction is in progress (state != IDLE)
//   grant_id    : index of the current or most recent grant
//   timeout_err : one-cycle pulse when the watchdog abandons a request
module sd_req_arbiter #(
    parameter int          N_REQ   = 3,
    parameter int          LBA_W   = 32,
    parameter logic [23:0] TIMEOUT = 24'd14318180,
    localparam int         ID_W    = $clog2(N_REQ)
) (
    input  logic                clk,
    input  logic                reset,
    sd_req_arbiter_if.master    bus,
    output logic                busy,
    output logic [ID_W-1:0]     grant_id,
    output logic                timeout_err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        XFER = 2'd2
    } state_t;

    state_t            state;
    state_t            state_next;

    logic [N_REQ-1:0]  pending;
    logic              pick_found;
    logic [ID_W-1:0]   pick_id;
    logic [ID_W-1:0]   cand;
    logic [LBA_W-1:0]  pick_lba;
    logic              grant_now;
    logic              wd_fire;

    logic [23:0]       wd_cnt;
    logic              host_rd_q;
    logic              host_wr_q;
    logic [LBA_W-1:0]  host_lba_q;

    // State register
    always_ff @(posedge clk) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_next;
    end

    // Round-robin pick: search starts one past the last grant and wraps,
    // so a requester that just finished (or timed out) goes to the back.
    always_comb begin
        pending    = bus.req_rd | bus.req_wr;
        pick_found = 1'b0;
        pick_id    = grant_id;
        cand       = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            cand = ID_W'((int'(grant_id) + k) % N_REQ);
            if (!pick_found && pending[cand]) begin
                pick_found = 1'b1;
                pick_id    = cand;
            end
        end
        pick_lba = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (pick_id == ID_W'(i))
                pick_lba = bus.req_lba[i*LBA_W +: LBA_W];
        end
        // A host_ack still high from before (reset or timeout) blocks new grants
        grant_now = (state == IDLE) && pick_found && !bus.host_ack;
        wd_fire   = (state == REQ) && !bus.host_ack && (TIMEOUT != 24'd0) &&
                    (wd_cnt == TIMEOUT - 24'd1);
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (grant_now) state_next = REQ;
            REQ:     begin
                         if (bus.host_ack)  state_next = XFER;
                         else if (wd_fire)  state_next = IDLE;
                     end
            XFER:    if (!bus.host_ack) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Grant latch, host request and watchdog. grant_id is deliberately kept
    // on timeout so the next search skips past the failed requester.
    always_ff @(posedge clk) begin
        if (reset) begin
            grant_id    <= ID_W'(N_REQ - 1);
            host_lba_q  <= '0;
            host_rd_q   <= 1'b0;
            host_wr_q   <= 1'b0;
            wd_cnt      <= '0;
            timeout_err <= 1'b0;
        end else begin
            timeout_err <= wd_fire;
            if (grant_now) begin
                grant_id   <= pick_id;
                host_lba_q <= pick_lba;
                // Read wins a rd/wr conflict; the write must be re-requested
                host_rd_q  <= bus.req_rd[pick_id];
                host_wr_q  <= bus.req_wr[pick_id] & ~bus.req_rd[pick_id];
                wd_cnt     <= '0;
            end else if (state == REQ) begin
                if (bus.host_ack || wd_fire) begin
                    host_rd_q <= 1'b0;
                    host_wr_q <= 1'b0;
                end
                if (!bus.host_ack && wd_cnt != 24'hFFFFFF)
                    wd_cnt <= wd_cnt + 24'd1;
            end
        end
    end

    // Output steering: ack, buffer strobe and write data follow the
    // granted requester with zero latency, and are forced to 0 in IDLE.
    always_comb begin
        busy              = (state != IDLE);
        bus.host_rd       = host_rd_q;
        bus.host_wr       = host_wr_q;
        bus.host_lba      = host_lba_q;
        bus.req_ack       = '0;
        bus.req_buff_wr   = '0;
        bus.host_buff_din = '0;
        if (state != IDLE) begin
            for (int i = 0; i < N_REQ; i++) begin
                if (grant_id == ID_W'(i)) begin
                    bus.req_ack[i]    = bus.host_ack;
                    bus.req_buff_wr[i] = bus.host_buff_wr;
                    bus.host_buff_din = bus.req_buff_din[i*8 +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_sd_req_arbiter.sv
// tb_sd_req_arbiter
// Directed bench for sd_req_arbiter (N_REQ = 3, LBA_W = 32, TIMEOUT = 16).
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_sd_req_arbiter;

    localparam int N_REQ = 3;
    localparam int LBA_W = 32;

    logic       clk = 1'b0;
    logic       reset;
    logic       busy;
    logic [1:0] grant_id;
    logic       timeout_err;

    int checks   = 0;
    int failures = 0;

    sd_req_arbiter_if #(.N_REQ(N_REQ), .LBA_W(LBA_W)) bus ();

    sd_req_arbiter #(
        .N_REQ   (N_REQ),
        .LBA_W   (LBA_W),
        .TIMEOUT (24'd16)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .bus         (bus),
        .busy        (busy),
        .grant_id    (grant_id),
        .timeout_err (timeout_err)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] actual,
                               input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic [2:0] rd, input logic [2:0] wr);
        bus.req_rd = rd;
        bus.req_wr = wr;
    endtask

    // Waits for a grant, checks it, runs a one-cycle transfer and returns
    // on the falling edge of the IDLE gap cycle.
    task automatic serveGrant(input int exp_id, input logic [31:0] exp_lba,
                              input bit re_request);
        int          waited;
        logic [63:0] one_hot;
        waited  = 0;
        one_hot = 64'd1 << exp_id;
        while (!(bus.host_rd || bus.host_wr) && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        checkOutput("grant_latency", 64'(waited), 64'd1);
        if (!(bus.host_rd || bus.host_wr))
            return;
        checkOutput("grant_id", grant_id, 64'(exp_id));
        checkOutput("grant_lba", bus.host_lba, exp_lba);
        bus.host_ack       = 1'b1;
        bus.req_rd[exp_id] = 1'b0;
        #1;
        checkOutput("ack_route", bus.req_ack, one_hot);
        @(negedge clk);
        checkOutput("xfer_rd_low", bus.host_rd, 64'd0);
        checkOutput("xfer_busy", busy, 64'd1);
        if (re_request)
            bus.req_rd[exp_id] = 1'b1;
        bus.host_ack = 1'b0;
        @(negedge clk);
        checkOutput("gap_idle", busy, 64'd0);
    endtask

    initial begin
        reset            = 1'b1;
        bus.req_rd       = '0;
        bus.req_wr       = '0;
        bus.req_lba      = '0;
        bus.req_buff_din = '0;
        bus.host_ack     = 1'b0;
        bus.host_buff_wr = 1'b0;
        repeat (2) @(negedge clk);

        // Reset state
        checkOutput("rst_busy", busy, 64'd0);
        checkOutput("rst_grant_id", grant_id, 64'd2);
        checkOutput("rst_host_rd", bus.host_rd, 64'd0);
        checkOutput("rst_host_wr", bus.host_wr, 64'd0);
        checkOutput("rst_req_ack", bus.req_ack, 64'd0);
        checkOutput("rst_timeout", timeout_err, 64'd0);
        checkOutput("rst_lba", bus.host_lba, 64'd0);
        reset = 1'b0;

        // Single read from requester 1
        @(negedge clk);
        bus.req_lba[63:32] = 32'h123;
        applyStimulus(3'b010, 3'b000);
        @(negedge clk);
        checkOutput("rd1_host_rd", bus.host_rd, 64'd1);
        checkOutput("rd1_host_wr", bus.host_wr, 64'd0);
        checkOutput("rd1_lba", bus.host_lba, 64'h123);
        checkOutput("rd1_grant", grant_id, 64'd1);
        checkOutput("rd1_busy", busy, 64'd1);
        repeat (4) @(negedge clk);
        checkOutput("rd1_rd_held", bus.host_rd, 64'd1);
        bus.host_ack = 1'b1;
        applyStimulus(3'b000, 3'b000);
        #1;
        checkOutput("rd1_ack_route", bus.req_ack, 64'b010);
        repeat (512) @(negedge clk);
        checkOutput("rd1_ack_hold", bus.req_ack, 64'b010);
        checkOutput("rd1_rd_low", bus.host_rd, 64'd0);
        bus.host_ack = 1'b0;
        #1;
        checkOutput("rd1_busy_before", busy, 64'd1);
        checkOutput("rd1_ack_drop", bus.req_ack, 64'd0);
        @(negedge clk);
        checkOutput("rd1_busy_after", busy, 64'd0);

        // Round-robin with requester 0 re-requesting during its transfer
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        bus.req_lba = {32'h102, 32'h101, 32'h100};
        applyStimulus(3'b111, 3'b000);
        serveGrant(0, 32'h100, 1'b1);
        serveGrant(1, 32'h101, 1'b0);
        serveGrant(2, 32'h102, 1'b0);
        serveGrant(0, 32'h100, 1'b0);

        // Write data path for requester 2
        bus.req_buff_din   = {8'hA5, 8'h5A, 8'h3C};
        bus.req_lba[95:64] = 32'h2A2;
        applyStimulus(3'b000, 3'b100);
        @(negedge clk);
        checkOutput("wr_host_wr", bus.host_wr, 64'd1);
        checkOutput("wr_host_rd", bus.host_rd, 64'd0);
        checkOutput("wr_grant", grant_id, 64'd2);
        checkOutput("wr_lba", bus.host_lba, 64'h2A2);
        bus.host_ack = 1'b1;
        applyStimulus(3'b000, 3'b000);
        @(negedge clk);
        bus.host_buff_wr = 1'b1;
        #1;
        checkOutput("wr_buff_din", bus.host_buff_din, 64'hA5);
        checkOutput("wr_buff_strobe", bus.req_buff_wr, 64'b100);
        @(negedge clk);
        bus.host_buff_wr = 1'b0;
        #1;
        checkOutput("wr_strobe_off", bus.req_buff_wr, 64'd0);
        bus.host_ack = 1'b0;
        @(negedge clk);
        checkOutput("wr_idle_busy", busy, 64'd0);
        checkOutput("wr_idle_din", bus.host_buff_din, 64'd0);

        // Watchdog: requester 0 never acked, then requester 1 wins
        applyStimulus(3'b011, 3'b000);
        @(negedge clk);
        checkOutput("to_grant0", grant_id, 64'd0);
        checkOutput("to_rd_high", bus.host_rd, 64'd1);
        repeat (15) @(negedge clk);
        checkOutput("to_rd_still", bus.host_rd, 64'd1);
        checkOutput("to_no_err_yet", timeout_err, 64'd0);
        @(negedge clk);
        checkOutput("to_rd_drop", bus.host_rd, 64'd0);
        checkOutput("to_err_pulse", timeout_err, 64'd1);
        checkOutput("to_busy_low", busy, 64'd0);
        checkOutput("to_grant_kept", grant_id, 64'd0);
        @(negedge clk);
        checkOutput("to_err_one_cycle", timeout_err, 64'd0);
        checkOutput("to_next_grant", grant_id, 64'd1);
        checkOutput("to_next_rd", bus.host_rd, 64'd1);
        checkOutput("to_next_lba", bus.host_lba, 64'h101);
        bus.host_ack = 1'b1;
        applyStimulus(3'b000, 3'b000);
        @(negedge clk);
        bus.host_ack = 1'b0;
        @(negedge clk);
        checkOutput("to_cleanup_idle", busy, 64'd0);

        // Reset mid-transfer with a stale host ack
        applyStimulus(3'b100, 3'b000);
        @(negedge clk);
        checkOutput("st_grant2", grant_id, 64'd2);
        bus.host_ack = 1'b1;
        @(negedge clk);
        checkOutput("st_in_xfer", busy, 64'd1);
        reset = 1'b1;
        @(negedge clk);
        checkOutput("st_rst_busy", busy, 64'd0);
        checkOutput("st_rst_rd", bus.host_rd, 64'd0);
        checkOutput("st_rst_ack", bus.req_ack, 64'd0);
        checkOutput("st_rst_grant", grant_id, 64'd2);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("st_blocked_busy", busy, 64'd0);
        checkOutput("st_blocked_rd", bus.host_rd, 64'd0);
        bus.host_ack = 1'b0;
        @(negedge clk);
        checkOutput("st_regrant", grant_id, 64'd2);
        checkOutput("st_regrant_rd", bus.host_rd, 64'd1);
        checkOutput("st_regrant_lba", bus.host_lba, 64'h2A2);
        bus.host_ack = 1'b1;
        applyStimulus(3'b000, 3'b000);
        @(negedge clk);
        bus.host_ack = 1'b0;
        @(negedge clk);

        // Read/write conflict on requester 0
        applyStimulus(3'b001, 3'b001);
        @(negedge clk);
        checkOutput("cf_grant", grant_id, 64'd0);
        checkOutput("cf_host_rd", bus.host_rd, 64'd1);
        checkOutput("cf_host_wr", bus.host_wr, 64'd0);
        bus.host_ack = 1'b1;
        applyStimulus(3'b000, 3'b000);
        @(negedge clk);
        bus.host_ack = 1'b0;
        @(negedge clk);
        checkOutput("cf_idle", busy, 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sd_req_arbiter.md
# sd_req_arbiter

Shares the single host sector channel (rd/wr/lba/ack plus the sector buffer data bus) between N block-device requesters: floppy track 1, HDD, and floppy track 2. It grants requests round-robin and serialises one sector transaction at a time. It latches the granted LBA and steers ack and buffer strobes to the winner only. A watchdog abandons requests the host never acknowledges. It sits between the per-drive controllers and the host bridge, in the `clk_pixel_14_318` domain.

## Interface
Parameters:
- `N_REQ`, 3: number of requesters, 2..4. Index 0 = floppy 1, 1 = HDD, 2 = floppy 2.
- `LBA_W`, 32: LBA width.
- `TIMEOUT`, 24'd14318180: cycles to wait in REQ for a host ack rise. 0 disables the watchdog.

Ports (clock and reset first):
- `clk` in 1: the single clock.
- `reset` in 1: reset, synchronous, active-high.
- `req_rd` in N_REQ: per-requester read request, level, held until its ack rises.
- `req_wr` in N_REQ: per-requester write request, same rules as `req_rd`.
- `req_lba` in N_REQ*LBA_W: requester i occupies `[i*LBA_W +: LBA_W]`.
- `req_buff_din` in N_REQ*8: requester write data, indexed like `req_lba`.
- `req_ack` out N_REQ: host ack routed to the granted requester only.
- `req_buff_wr` out N_REQ: host buffer write strobe, routed to the granted requester only.
- `host_rd` out 1: sector read request to the host.
- `host_wr` out 1: sector write request to the host.
- `host_lba` out LBA_W: LBA latched at grant.
- `host_ack` in 1: high for the whole transfer.
- `host_buff_wr` in 1: host buffer write strobe.
- `host_buff_din` out 8: granted requester's `req_buff_din`.
- `busy` out 1: high whenever state ≠ IDLE.
- `grant_id` out clog2(N_REQ): index of the current or last grant.
- `timeout_err` out 1: one-cycle pulse when the watchdog fires.

## Operation
- States: IDLE, REQ, XFER.
- **IDLE**
  - Pending = `req_rd | req_wr`.
  - If pending ≠ 0 and `host_ack` = 0: pick the first pending index searching from `grant_id+1` and wrapping modulo N_REQ.
  - Register `grant_id` and `host_lba`.
  - Set `host_rd` = `req_rd[g]`, `host_wr` = `req_wr[g] & ~req_rd[g]`. Read wins if both are set; the write must be re-requested.
  - Clear the watchdog counter and go to REQ.
  - If `host_ack` is still high (stale from reset or timeout), no grant is issued.
- **REQ**
  - On `host_ack` = 1: clear `host_rd`/`host_wr` and go to XFER.
  - Otherwise increment the counter. When counter = TIMEOUT−1 (and TIMEOUT ≠ 0): clear `host_rd`/`host_wr`, pulse `timeout_err`, go to IDLE.
  - `grant_id` is kept on timeout, so the next search starts past the failed requester.
- **XFER**
  - On `host_ack` = 0: go to IDLE.
  - No watchdog in this state.
- Combinational steering, valid in REQ and XFER and 0 in IDLE:
  - `req_ack[i]` = `host_ack & (grant_id==i)`
  - `req_buff_wr[i]` = `host_buff_wr & (grant_id==i)`
  - `host_buff_din` = `req_buff_din[grant_id]`
- Requester input changes after grant (LBA, rd/wr) have no effect on the active transaction.
- Watchdog counter is 24 bits, saturating; it never wraps.

## Timing
- Reset: state IDLE, `grant_id` = N_REQ−1 (so requester 0 wins first), all outputs 0, counter 0.
- A reset asserted mid-transaction drops `host_rd`/`host_wr` on the next edge. No ack is routed after that.
- Grant latency:
  - Request sampled at edge t → `host_rd`/`host_wr` and `host_lba` valid after edge t.
  - `busy` rises at the same edge.
- `host_ack` sampled high at edge t → `host_rd` low after edge t.
  - `req_ack[g]` follows `host_ack` with zero latency, so requesters drop their request in the same window.
- `host_ack` sampled low in XFER at edge t → IDLE after t. The earliest next grant is at edge t+1.
  - Back-to-back sectors therefore have a 1-cycle IDLE gap.
- Simultaneous requests: round-robin order, no starvation.
  - With all N_REQ requesting continuously, each requester is served once per N_REQ transactions.
- `timeout_err` is high exactly one cycle, coincident with the REQ→IDLE transition.

## Test plan
- **Single read.** `req_rd[1]` = 1, LBA 0x123 for requester 1. Host acks 4 cycles after `host_rd`, holds ack 512 cycles.
  - `host_rd` = 1 with `host_lba` = 0x123 one edge after the request.
  - `req_ack` = 3'b010 while ack is high; `busy` falls one edge after ack falls.
- **Round-robin.** All three assert `req_rd` after reset.
  - Grants in order 0, 1, 2.
  - Requester 0 re-requests during its XFER: the order continues 1, 2, 0.
- **Write data path.** `req_wr[2]`, `req_buff_din[2]` = 0xA5, `req_buff_din[0]` = 0x3C, `host_buff_wr` pulsed.
  - `host_buff_din` = 0xA5; `req_buff_wr` = 3'b100 only.
- **Timeout.** TIMEOUT = 16, `req_rd[0]`, host never acks.
  - `host_rd` drops after 16 REQ cycles with a one-cycle `timeout_err`.
  - With requesters 0 and 1 pending, the next grant goes to 1.
- **Stale ack / reset.** Reset asserted in XFER while `host_ack` stays high, `req_rd[2]` pending.
  - Outputs go to 0; no grant until `host_ack` = 0.
  - Then requester 0 is checked first and 2 is granted.
- **Read/write conflict.** `req_rd[0]` and `req_wr[0]` both set.
  - `host_rd` = 1, `host_wr` = 0.
